// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, register selects, phase tokens and FSM states
package cpu_pkg;
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_ADD   = 2'b11;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  localparam logic [1:0] PH_REQ  = 2'b10;
  localparam logic [1:0] PH_IDLE = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_WB,
    ST_HOLD
  } state_e;
endpackage

// File: rtl/cpu_mem.sv
// rtl/cpu_mem.sv - 16x8 memory, synchronous write, two combinational read ports
// Contents are never reset so preloaded programs survive a core reset.
module cpu_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr0_i,
  output logic [DATA_W-1:0] rdata0_o,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o
);
  logic [DATA_W-1:0] memoria [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we_i) memoria[waddr_i] <= wdata_i;
  end

  assign rdata0_o = memoria[raddr0_i];
  assign rdata1_o = memoria[raddr1_i];
endmodule

// File: rtl/cpu.sv
// rtl/cpu.sv - phase-driven accumulator CPU with four-phase ack handshakes
// Fetch/execute/write-back are triggered by dual-rail phase tokens, one request at a time.
module cpu
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] PH0,
  input  logic [1:0] PH1,
  input  logic [1:0] PH2,
  input  logic [7:0] mem_addr_input,
  output logic       mem_ack_read,
  output logic       mem_ack_write,
  output logic       ack_write_cache,
  output logic       ack_read_cache
);
  logic [DATA_W-1:0] reg_a, reg_b, reg_c, reg_d, ir, mdr;
  logic [DATA_W-1:0] fetch_data, exec_data, cur_reg, wb_val;
  logic [2:0] req, rise, cand, grant;
  logic [2:0] prev_q, pend_q, pend_d, owner_q, owner_d;
  logic       release_ack, mem_we;
  logic [1:0] op, rsel;
  logic [ADDR_W-1:0] maddr;
  logic [3:0] unused_addr_hi;
  state_e     state_q, state_d;

  assign unused_addr_hi = mem_addr_input[7:4];
  assign op    = ir[7:6];
  assign rsel  = ir[5:4];
  assign maddr = ir[ADDR_W-1:0];
  assign req   = {PH2 == PH_REQ, PH1 == PH_REQ, PH0 == PH_REQ};
  assign rise  = req & ~prev_q;
  // A request that lost arbitration stays pending until it is served or dropped.
  assign cand  = req & (rise | pend_q);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    grant       = 3'b000;
    release_ack = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cand[0]) begin
          grant   = 3'b001;
          state_d = ST_FETCH;
        end else if (cand[1]) begin
          grant   = 3'b010;
          state_d = ST_EXEC;
        end else if (cand[2]) begin
          grant   = 3'b100;
          state_d = ST_WB;
        end
        if (|grant) owner_d = grant;
      end
      default: begin
        if (|(owner_q & req)) begin
          state_d = ST_HOLD;
        end else begin
          state_d     = ST_IDLE;
          release_ack = 1'b1;
        end
      end
    endcase
    pend_d = (pend_q | rise) & req & ~grant;
  end

  always_comb begin
    cur_reg = reg_a;
    case (rsel)
      SEL_A:   cur_reg = reg_a;
      SEL_B:   cur_reg = reg_b;
      SEL_C:   cur_reg = reg_c;
      default: cur_reg = reg_d;
    endcase
  end

  assign wb_val = (op == OP_ADD) ? cur_reg + mdr : mdr;
  assign mem_we = grant[1] && (op == OP_STORE) && rst_n;

  cpu_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) memoria (
    .clk      (clk),
    .we_i     (mem_we),
    .waddr_i  (maddr),
    .wdata_i  (cur_reg),
    .raddr0_i (mem_addr_input[ADDR_W-1:0]),
    .rdata0_o (fetch_data),
    .raddr1_i (maddr),
    .rdata1_o (exec_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      prev_q          <= '0;
      pend_q          <= '0;
      owner_q         <= '0;
      reg_a           <= '0;
      reg_b           <= '0;
      reg_c           <= '0;
      reg_d           <= '0;
      ir              <= '0;
      mdr             <= '0;
      mem_ack_read    <= 1'b0;
      mem_ack_write   <= 1'b0;
      ack_write_cache <= 1'b0;
      ack_read_cache  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= req;
      pend_q  <= pend_d;
      owner_q <= owner_d;
      if (release_ack) begin
        mem_ack_read    <= 1'b0;
        mem_ack_write   <= 1'b0;
        ack_write_cache <= 1'b0;
        ack_read_cache  <= 1'b0;
      end
      if (grant[0]) begin
        ir           <= fetch_data;
        mem_ack_read <= 1'b1;
      end
      if (grant[1]) begin
        case (op)
          OP_LOAD, OP_ADD: begin
            mdr          <= exec_data;
            mem_ack_read <= 1'b1;
          end
          OP_STORE: begin
            ack_read_cache <= 1'b1;
            mem_ack_write  <= 1'b1;
          end
          default: ;
        endcase
      end
      if (grant[2] && (op == OP_LOAD || op == OP_ADD)) begin
        ack_write_cache <= 1'b1;
        case (rsel)
          SEL_A:   reg_a <= wb_val;
          SEL_B:   reg_b <= wb_val;
          SEL_C:   reg_c <= wb_val;
          default: reg_d <= wb_val;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - scoreboard bench for the phase-driven cpu
module tb_cpu;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] PH0, PH1, PH2;
  logic [7:0] mem_addr_input;
  logic       mem_ack_read, mem_ack_write, ack_write_cache, ack_read_cache;

  always #5 clk = ~clk;

  cpu dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .PH0             (PH0),
    .PH1             (PH1),
    .PH2             (PH2),
    .mem_addr_input  (mem_addr_input),
    .mem_ack_read    (mem_ack_read),
    .mem_ack_write   (mem_ack_write),
    .ack_write_cache (ack_write_cache),
    .ack_read_cache  (ack_read_cache)
  );

  // sel: 0 ir, 1 mdr, 2..5 reg_a..reg_d, 6 memoria[addr]
  typedef struct {
    logic [3:0] acks;
    int         sel;
    logic [3:0] addr;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;
  logic [3:0] prev_acks = 4'h0;

  function automatic logic [3:0] acks();
    return {mem_ack_read, mem_ack_write, ack_read_cache, ack_write_cache};
  endfunction

  function automatic logic [7:0] probe(int sel, logic [3:0] a);
    case (sel)
      0:       return dut.ir;
      1:       return dut.mdr;
      2:       return dut.reg_a;
      3:       return dut.reg_b;
      4:       return dut.reg_c;
      5:       return dut.reg_d;
      default: return dut.memoria.memoria[a];
    endcase
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ack(logic [3:0] ak, int sel, logic [3:0] ad, logic [7:0] v, string name);
    exp_t e;
    e.acks = ak; e.sel = sel; e.addr = ad; e.val = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic set_ph(int p, logic [1:0] v);
    case (p)
      0:       PH0 = v;
      1:       PH1 = v;
      default: PH2 = v;
    endcase
  endtask

  task automatic run(int p, int hold, string name);
    @(posedge clk); #1 set_ph(p, 2'b10);
    repeat (1 + hold) @(posedge clk);
    #1 set_ph(p, 2'b00);
    @(posedge clk); #1 chk({name, "_ack_clear"}, {4'h0, acks()}, 8'h00);
  endtask

  always @(negedge clk) begin
    logic [3:0] a;
    exp_t e;
    a = acks();
    if (a != 4'h0 && prev_acks == 4'h0) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", {4'h0, a}, 8'h00);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_acks"}, {4'h0, a}, {4'h0, e.acks});
        chk({e.name, "_data"}, probe(e.sel, e.addr), e.val);
      end
    end
    prev_acks = a;
  end

  initial begin
    dut.memoria.memoria[0]  = 8'h8F;
    dut.memoria.memoria[1]  = 8'h47;
    dut.memoria.memoria[2]  = 8'h97;
    dut.memoria.memoria[3]  = 8'hE7;
    dut.memoria.memoria[5]  = 8'h00;
    dut.memoria.memoria[7]  = 8'h00;
    dut.memoria.memoria[15] = 8'hCC;
    rst_n = 1'b0; PH0 = 2'b00; PH1 = 2'b00; PH2 = 2'b00; mem_addr_input = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_acks", {4'h0, acks()}, 8'h00);
    chk("rst_reg_a", dut.reg_a, 8'h00);
    chk("rst_reg_b", dut.reg_b, 8'h00);
    chk("rst_reg_c", dut.reg_c, 8'h00);
    chk("rst_reg_d", dut.reg_d, 8'h00);
    chk("rst_ir", dut.ir, 8'h00);
    chk("rst_mdr", dut.mdr, 8'h00);
    chk("rst_mem0_kept", dut.memoria.memoria[0], 8'h8F);
    rst_n = 1'b1;

    mem_addr_input = 8'h00;
    expect_ack(4'b1000, 0, 0, 8'h8F, "load_a_fetch"); run(0, 0, "load_a_fetch");
    expect_ack(4'b1000, 1, 0, 8'hCC, "load_a_exec");  run(1, 0, "load_a_exec");
    expect_ack(4'b0001, 2, 0, 8'hCC, "load_a_wb");    run(2, 2, "load_a_wb");

    mem_addr_input = 8'h01;
    expect_ack(4'b1000, 0, 0, 8'h47, "store_a_fetch"); run(0, 0, "store_a_fetch");
    expect_ack(4'b0110, 6, 7, 8'hCC, "store_a_exec");  run(1, 1, "store_a_exec");

    mem_addr_input = 8'h02;
    expect_ack(4'b1000, 0, 0, 8'h97, "load_b_fetch"); run(0, 0, "load_b_fetch");
    expect_ack(4'b1000, 1, 0, 8'hCC, "load_b_exec");  run(1, 0, "load_b_exec");
    expect_ack(4'b0001, 3, 0, 8'hCC, "load_b_wb");    run(2, 0, "load_b_wb");

    mem_addr_input = 8'h55;
    expect_ack(4'b1000, 0, 0, 8'h00, "nop_fetch"); run(0, 0, "nop_fetch");
    run(1, 1, "nop_exec");
    run(2, 1, "nop_wb");
    chk("nop_reg_a", dut.reg_a, 8'hCC);
    chk("nop_reg_b", dut.reg_b, 8'hCC);
    chk("nop_reg_c", dut.reg_c, 8'h00);
    chk("nop_reg_d", dut.reg_d, 8'h00);
    chk("nop_mdr", dut.mdr, 8'hCC);

    mem_addr_input = 8'h03;
    expect_ack(4'b1000, 0, 0, 8'hE7, "add_c_fetch"); run(0, 0, "add_c_fetch");
    expect_ack(4'b1000, 1, 0, 8'hCC, "add_c_exec1"); run(1, 0, "add_c_exec1");
    expect_ack(4'b0001, 4, 0, 8'hCC, "add_c_wb1");   run(2, 0, "add_c_wb1");
    expect_ack(4'b1000, 1, 0, 8'hCC, "add_c_exec2"); run(1, 0, "add_c_exec2");
    expect_ack(4'b0001, 4, 0, 8'h98, "add_c_wb2");   run(2, 0, "add_c_wb2");

    mem_addr_input = 8'h01;
    expect_ack(4'b1000, 0, 0, 8'h47, "ovl_fetch"); run(0, 0, "ovl_fetch");
    dut.memoria.memoria[7] = 8'h00;
    expect_ack(4'b0110, 6, 7, 8'hCC, "ovl_store");
    @(posedge clk); #1 PH0 = 2'b01; PH1 = 2'b10;
    @(posedge clk);
    @(posedge clk); #1 dut.memoria.memoria[7] = 8'h11;
    repeat (3) @(posedge clk);
    #1 PH0 = 2'b00; PH1 = 2'b00;
    @(posedge clk); #1;
    chk("ovl_ack_clear", {4'h0, acks()}, 8'h00);
    chk("ovl_store_once", dut.memoria.memoria[7], 8'h11);

    mem_addr_input = 8'h02;
    expect_ack(4'b1000, 0, 0, 8'h97, "prio_fetch");
    expect_ack(4'b1000, 1, 0, 8'h11, "prio_exec");
    @(posedge clk); #1 PH0 = 2'b10; PH1 = 2'b10;
    repeat (2) @(posedge clk);
    #1 PH0 = 2'b00;
    repeat (3) @(posedge clk);
    #1 PH1 = 2'b00;
    @(posedge clk); #1 chk("prio_ack_clear", {4'h0, acks()}, 8'h00);
    expect_ack(4'b0001, 3, 0, 8'h11, "prio_wb"); run(2, 0, "prio_wb");

    mem_addr_input = 8'h00;
    expect_ack(4'b1000, 0, 0, 8'h8F, "rst_fetch");
    @(posedge clk); #1 PH0 = 2'b10;
    @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("midrst_acks", {4'h0, acks()}, 8'h00);
    chk("midrst_ir", dut.ir, 8'h00);
    chk("midrst_reg_b", dut.reg_b, 8'h00);
    chk("midrst_reg_c", dut.reg_c, 8'h00);
    chk("midrst_mdr", dut.mdr, 8'h00);
    chk("midrst_mem7_kept", dut.memoria.memoria[7], 8'h11);
    PH0 = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    mem_addr_input = 8'h01;
    expect_ack(4'b1000, 0, 0, 8'h47, "post_rst_fetch"); run(0, 0, "post_rst_fetch");

    repeat (2) @(posedge clk);
    chk("sb_drained", 8'(sb.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-002 SHALL have port `rst_n`, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have ports `PH0`, `PH1`, `PH2`, input, 2 bits each: dual-rail phase tokens (fetch, execute, write-back); 2'b10 = request, 2'b00 or 2'b01 = no request, 2'b11 treated as no request.
REQ-004 SHALL have port `mem_addr_input`, input, 8 bits: instruction fetch address; only bits [3:0] are used.
REQ-005 SHALL have port `mem_ack_read`, output, 1 bit: data memory read acknowledge.
REQ-006 SHALL have port `mem_ack_write`, output, 1 bit: data memory write acknowledge.
REQ-007 SHALL have port `ack_write_cache`, output, 1 bit: register file write acknowledge.
REQ-008 SHALL have port `ack_read_cache`, output, 1 bit: register file read acknowledge.
REQ-009 SHALL have parameters ADDR_W=4 (memory address bits) and DATA_W=8 (data width).

Function
REQ-010 SHALL contain a 16x8 memory, instance `memoria`, with storage array `memoria[0:15]`, hierarchically writable by a bench at time 0.
REQ-011 SHALL hold four 8-bit registers `reg_a`, `reg_b`, `reg_c`, `reg_d`, plus 8-bit `ir` (instruction) and `mdr` (memory data).
REQ-012 SHALL decode the instruction as: [7:6] opcode, [5:4] register select (00=A, 01=B, 10=C, 11=D), [3:0] memory address.
REQ-013 SHALL implement the opcodes:
- 00 = NOP.
- 01 = STORE: memoria[addr] <= reg.
- 10 = LOAD: reg <= memoria[addr].
- 11 = ADD: reg <= reg + memoria[addr], modulo 256, carry discarded.
REQ-014 SHALL sample the PHx inputs every clock and act once per request, on the first edge where PHx==2'b10 and it was not 2'b10 on the previous edge.
REQ-015 SHALL handle a PH0 request by setting ir <= memoria[mem_addr_input[3:0]] and mem_ack_read <= 1.
REQ-016 SHALL handle a PH1 request as follows:
- LOAD/ADD: mdr <= memoria[addr]; mem_ack_read <= 1.
- STORE: memoria[addr] <= reg; ack_read_cache <= 1; mem_ack_write <= 1.
- NOP: no ack.
REQ-017 SHALL handle a PH2 request as follows:
- LOAD: reg <= mdr.
- ADD: reg <= reg + mdr.
- Both assert ack_write_cache <= 1.
- STORE/NOP: no write and no ack.
REQ-018 SHALL raise each ack exactly 1 clock after the request is sampled, hold it while that request stays 2'b10, and clear it on the first edge where the request is not 2'b10 (four-phase handshake).
REQ-019 SHALL, when more than one phase requests on the same edge, service only the lowest-numbered phase (PH0 > PH1 > PH2); the others are serviced once the winner is released, provided they are still requesting.
REQ-020 SHALL implement a state machine IDLE -> FETCH (PH0) / EXEC (PH1) / WB (PH2) -> HOLD (until the request is released) -> IDLE.
REQ-021 SHALL execute PH1/PH2 on the current ir, with no checking of phase order.

Reset
REQ-022 SHALL, while rst_n=0, clear all four acks, reg_a..reg_d, ir, mdr and the phase history registers to 0, with the state machine in IDLE, immediately and without waiting for a clock.
REQ-023 SHALL NOT reset memoria, so preloaded contents survive reset.
REQ-024 SHALL abandon any in-progress operation on reset mid-operation; a memory write only occurs if its clock edge preceded the reset.

Structure
REQ-025 SHALL place the opcode constants (NOP/STORE/LOAD/ADD), the register-select codes, the phase encodings (REQ=2'b10, IDLE=2'b00) and the state enum in a shared package `cpu_pkg`.
REQ-026 SHALL implement the memory as one sub-module `cpu_mem` (16x8, synchronous write, combinational read), instantiated as `memoria`.

Verification
REQ-027 SHALL cover reset: rst_n=0 -> all acks 0, reg_a..reg_d=0, ir=0; memoria contents unchanged.
REQ-028 SHALL cover LOAD_A: with memoria[0]=8'h8F and memoria[15]=8'hCC, PH0=10 at addr 0 -> ir=8'h8F and mem_ack_read=1 after 1 clk; PH1=10 -> mdr=8'hCC with mem_ack_read; PH2=10 -> reg_a=8'hCC with ack_write_cache; each ack returns to 0 one clk after its release.
REQ-029 SHALL cover STORE_A: fetch memoria[1]=8'h47, then PH1=10 -> ack_read_cache=1, mem_ack_write=1, memoria[7]=8'hCC.
REQ-030 SHALL cover LOAD_B: fetch memoria[2]=8'h97, PH1 then PH2 -> reg_b=8'hCC.
REQ-031 SHALL cover NOP: PH0 with mem_addr_input=8'h55 (memoria[5]=0) -> ir=0; a following PH1 and PH2 give no acks and no register change.
REQ-032 SHALL cover overlap and reset: PH0=01 with PH1=10 -> only PH1 serviced; holding PH1=10 for 5 clks writes memory once; rst_n=0 during a held ack clears it at once.
